// File: rtl/or_accum16.sv
// Frame OR-accumulator: ORs every 16-bit word of a frame together, counts the
// words (saturating) and holds the result until the downstream consumer takes it.
module or_accum16 #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_all_ones
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q;
    logic [15:0]      acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      out_data_q;
    logic [CNT_W-1:0] out_count_q;

    logic             accept;
    logic [15:0]      acc_d;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        accept = in_valid && (state_q == ACCUM);
        acc_d  = acc_q | in_data;
        cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        if (in_last) begin
                            // Last word goes straight into the result; the
                            // accumulator restarts clean for the next frame.
                            out_data_q  <= acc_d;
                            out_count_q <= cnt_d;
                            acc_q       <= '0;
                            cnt_q       <= '0;
                            state_q     <= HOLD;
                        end else begin
                            acc_q <= acc_d;
                            cnt_q <= cnt_d;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    // Handshake flags decode purely from the registered state.
    assign in_ready     = (state_q == ACCUM);
    assign out_valid    = (state_q == HOLD);
    assign out_data     = out_data_q;
    assign out_count    = out_count_q;
    assign out_all_ones = &out_data_q;

endmodule

// File: tb/tb_or_accum16.sv
// Directed self-checking bench for or_accum16: frame ORs, counts, backpressure,
// saturation and asynchronous reset behaviour.
module tb_or_accum16;

    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_all_ones;

    int n_checks = 0;
    int n_fails  = 0;

    or_accum16 #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_count    (out_count),
        .out_all_ones (out_all_ones)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Present one word for one rising edge; returns #1 after that edge.
    task automatic send_word(input logic [15:0] d, input logic last);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic [15:0] d,
                                input logic [CNT_W-1:0] c, input logic ones);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(d));
        check({tag, "_count"}, 32'(out_count), 32'(c));
        check({tag, "_ones"}, 32'(out_all_ones), 32'(ones));
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Words offered during reset must be ignored.
        #2;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        send_word(16'hFFFF, 1'b1);
        send_word(16'hFFFF, 1'b1);
        check("rst_hold_valid", 32'(out_valid), 32'd0);
        check("rst_hold_data", 32'(out_data), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        reset_n  = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);

        // Two-word frame, result one cycle after the last word.
        send_word(16'h046A, 1'b0);
        check("two_mid_valid", 32'(out_valid), 32'd0);
        send_word(16'hDE57, 1'b1);
        check_result("two", 16'hDE7F, 5'd2, 1'b0);
        check("two_hold_ready", 32'(in_ready), 32'd0);
        idle_cycle();
        check("two_pop_valid", 32'(out_valid), 32'd0);
        check("two_pop_data_kept", 32'(out_data), 32'hDE7F);

        // Single zero word.
        send_word(16'h0000, 1'b1);
        check_result("single", 16'h0000, 5'd1, 1'b0);
        idle_cycle();

        // Three words ORing to all ones.
        send_word(16'h2F2E, 1'b0);
        send_word(16'hF6D8, 1'b0);
        send_word(16'h0001, 1'b1);
        check_result("ones", 16'hFFFF, 5'd3, 1'b1);
        idle_cycle();

        // Backpressure: pending result with stalled AAAA words offered.
        out_ready = 1'b0;
        send_word(16'h0F00, 1'b1);
        check_result("bp", 16'h0F00, 5'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send_word(16'hAAAA, 1'b0);
            check($sformatf("bp_ready_%0d", i), 32'(in_ready), 32'd0);
            check_result($sformatf("bp_stall_%0d", i), 16'h0F00, 5'd1, 1'b0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        send_word(16'h0005, 1'b1);
        check_result("bp_next", 16'h0005, 5'd1, 1'b0);
        idle_cycle();

        // Counter saturation.
        for (int i = 0; i < 40; i++) begin
            send_word(16'h0001, (i == 39));
        end
        check_result("sat", 16'h0001, 5'd31, 1'b0);
        idle_cycle();

        // Back-to-back 2-word frames with in_valid held: 3 cycles per frame.
        send_word(16'h0001, 1'b0);
        send_word(16'h0002, 1'b1);
        check_result("tput_a", 16'h0003, 5'd2, 1'b0);
        send_word(16'h0010, 1'b0);
        check("tput_pop_valid", 32'(out_valid), 32'd0);
        send_word(16'h0010, 1'b0);
        send_word(16'h0020, 1'b1);
        check_result("tput_b", 16'h0030, 5'd2, 1'b0);
        idle_cycle();

        // Asynchronous reset while a result is held.
        out_ready = 1'b0;
        send_word(16'hBEEF, 1'b1);
        check_result("arst_pre", 16'hBEEF, 5'd1, 1'b0);
        reset_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data", 32'(out_data), 32'd0);
        check("arst_count", 32'(out_count), 32'd0);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        idle_cycle();

        // Reset mid-frame discards the partial accumulation.
        send_word(16'hFF00, 1'b0);
        send_word(16'h00F0, 1'b0);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        #1;
        reset_n = 1'b1;
        send_word(16'h1234, 1'b1);
        check_result("mid_rst_frame", 16'h1234, 5'd1, 1'b0);
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
